// File: rtl/fetch_decode_if.sv
// fetch_decode_if: bundles the instruction-memory fetch port and the decoded
// instruction / control port between the fetch_decode front end and its
// environment (instruction memory + rsreg issue stage).
//  master : fetch_decode side (drives imem_req/imem_addr, decoded fields, halted)
//  slave  : environment side (drives imem_ack/imem_rdata, npc/get_npc, is_busy)
// Signals:
//  imem_req/imem_addr        fetch request pulse and address
//  imem_ack/imem_rdata       fetch completion pulse and instruction word
//  opcode rd fun3 rs1 rs2    decoded instruction fields to rsreg
//  fun7 imm opc              decoded fun7, sign-extended immediate, instruction PC
//  npc/get_npc               resolved next PC from rsreg and its valid strobe
//  is_busy                   rsreg cannot accept an instruction this cycle
//  halted                    sticky illegal-opcode indication
interface fetch_decode_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  fun3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  fun7;
  logic [31:0] imm;
  logic [31:0] opc;
  logic [31:0] npc;
  logic        get_npc;
  logic        is_busy;
  logic        halted;

  modport master (
    output imem_req, imem_addr,
    output opcode, rd, fun3, rs1, rs2, fun7, imm, opc, halted,
    input  imem_ack, imem_rdata, npc, get_npc, is_busy
  );

  modport slave (
    input  imem_req, imem_addr,
    input  opcode, rd, fun3, rs1, rs2, fun7, imm, opc, halted,
    output imem_ack, imem_rdata, npc, get_npc, is_busy
  );
endinterface

// File: rtl/fetch_decode.sv
// fetch_decode: in-order RV32I fetch + decode front end feeding rsreg.
// Fetches one word at a time from instruction memory, decodes it into
// opcode/rd/fun3/rs1/rs2/fun7/imm and presents it for exactly one cycle
// when rsreg is not busy; otherwise the outputs hold the canonical NOP
// (ADDI x0,x0,0). Branches and JALR stall fetch until rsreg returns npc.
// Ports:
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  bus    fetch_decode_if.master (imem fetch port + rsreg decode port)
// Parameters:
//  RESET_PC         PC loaded on reset
//  HALT_ON_ILLEGAL  1: unknown opcode halts; 0: unknown opcode dropped as NOP
module fetch_decode #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_decode_if.master bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_BRWAIT,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ibuf;

  // Decoded view of ibuf
  logic [6:0]  d_opcode;
  logic [4:0]  d_rd;
  logic [2:0]  d_fun3;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [6:0]  d_fun7;
  logic [31:0] d_imm;
  logic        d_legal;
  logic        d_wait_npc;
  logic        d_is_jal;

  // Combinational decode of the buffered word. Fields a format does not use
  // are forced to zero so rsreg never sees a false register dependency.
  always_comb begin
    d_opcode   = ibuf[6:0];
    d_rd       = ibuf[11:7];
    d_fun3     = ibuf[14:12];
    d_rs1      = ibuf[19:15];
    d_rs2      = ibuf[24:20];
    d_fun7     = '0;
    d_imm      = '0;
    d_legal    = 1'b1;
    d_wait_npc = 1'b0;
    d_is_jal   = 1'b0;

    case (ibuf[6:0])
      OPC_LUI, OPC_AUIPC: begin
        d_rs1 = '0;
        d_rs2 = '0;
        d_imm = {ibuf[31:12], 12'b0};
      end
      OPC_JAL: begin
        d_rs1    = '0;
        d_rs2    = '0;
        d_imm    = {{11{ibuf[31]}}, ibuf[31], ibuf[19:12], ibuf[20],
                    ibuf[30:21], 1'b0};
        d_is_jal = 1'b1;
      end
      OPC_JALR: begin
        d_rs2      = '0;
        d_imm      = {{20{ibuf[31]}}, ibuf[31:20]};
        d_wait_npc = 1'b1;
      end
      OPC_LOAD: begin
        d_rs2 = '0;
        d_imm = {{20{ibuf[31]}}, ibuf[31:20]};
      end
      OPC_OP_IMM: begin
        d_rs2 = '0;
        d_imm = {{20{ibuf[31]}}, ibuf[31:20]};
        // Shift-immediates carry the arithmetic/logical selector in [31:25]
        if (ibuf[14:12] == 3'b001 || ibuf[14:12] == 3'b101) begin
          d_fun7 = ibuf[31:25];
        end
      end
      OPC_BRANCH: begin
        d_rd       = '0;
        d_imm      = {{19{ibuf[31]}}, ibuf[31], ibuf[7], ibuf[30:25],
                      ibuf[11:8], 1'b0};
        d_wait_npc = 1'b1;
      end
      OPC_STORE: begin
        d_rd  = '0;
        d_imm = {{20{ibuf[31]}}, ibuf[31:25], ibuf[11:7]};
      end
      OPC_OP: begin
        d_fun7 = ibuf[31:25];
      end
      default: begin
        d_legal = 1'b0;
      end
    endcase
  end

  // Single registered FSM; every output is a flop. Decode outputs default
  // to NOP each cycle and are overwritten only on the issue edge, so an
  // instruction is visible for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      ibuf          <= '0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
      bus.halted    <= 1'b0;
      bus.opcode    <= OPC_OP_IMM;
      bus.rd        <= '0;
      bus.fun3      <= '0;
      bus.rs1       <= '0;
      bus.rs2       <= '0;
      bus.fun7      <= '0;
      bus.imm       <= '0;
      bus.opc       <= '0;
    end else begin
      bus.imem_req <= 1'b0;
      bus.opcode   <= OPC_OP_IMM;
      bus.rd       <= '0;
      bus.fun3     <= '0;
      bus.rs1      <= '0;
      bus.rs2      <= '0;
      bus.fun7     <= '0;
      bus.imm      <= '0;
      bus.opc      <= '0;

      case (state)
        S_FETCH: begin
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= pc;
          state         <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.imem_ack) begin
            // Canonical NOP words never occupy an issue slot
            if (bus.imem_rdata == NOP_WORD) begin
              pc    <= pc + 32'd4;
              state <= S_FETCH;
            end else begin
              ibuf  <= bus.imem_rdata;
              state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (!d_legal) begin
            if (HALT_ON_ILLEGAL) begin
              bus.halted <= 1'b1;
              state      <= S_HALT;
            end else begin
              pc    <= pc + 32'd4;
              state <= S_FETCH;
            end
          end else if (!bus.is_busy) begin
            bus.opcode <= d_opcode;
            bus.rd     <= d_rd;
            bus.fun3   <= d_fun3;
            bus.rs1    <= d_rs1;
            bus.rs2    <= d_rs2;
            bus.fun7   <= d_fun7;
            bus.imm    <= d_imm;
            bus.opc    <= pc;
            if (d_wait_npc) begin
              state <= S_BRWAIT;
            end else if (d_is_jal) begin
              pc    <= pc + d_imm;
              state <= S_FETCH;
            end else begin
              pc    <= pc + 32'd4;
              state <= S_FETCH;
            end
          end
        end

        S_BRWAIT: begin
          if (bus.get_npc) begin
            pc    <= bus.npc;
            state <= S_FETCH;
          end
        end

        S_HALT: begin
          bus.halted <= 1'b1;
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  localparam logic [6:0] M_LUI    = 7'b0110111;
  localparam logic [6:0] M_AUIPC  = 7'b0010111;
  localparam logic [6:0] M_JAL    = 7'b1101111;
  localparam logic [6:0] M_JALR   = 7'b1100111;
  localparam logic [6:0] M_BRANCH = 7'b1100011;
  localparam logic [6:0] M_LOAD   = 7'b0000011;
  localparam logic [6:0] M_STORE  = 7'b0100011;
  localparam logic [6:0] M_OPIMM  = 7'b0010011;
  localparam logic [6:0] M_OP     = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  fun3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  fun7;
    logic [31:0] imm;
    logic [31:0] opc;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_decode_if bus();

  fetch_decode #(
    .RESET_PC(RST_PC),
    .HALT_ON_ILLEGAL(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  dec_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_pc;
  logic        busy_rand = 1'b0;
  logic        busy_level = 1'b0;
  logic        busy_q = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode expressed directly from the RV32I format rules
  function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    logic [6:0] op;
    logic is_u, is_j, is_i, is_s, is_b, is_r;
    int   simm;
    op   = w[6:0];
    is_u = (op == M_LUI) || (op == M_AUIPC);
    is_j = (op == M_JAL);
    is_i = (op == M_JALR) || (op == M_LOAD) || (op == M_OPIMM);
    is_s = (op == M_STORE);
    is_b = (op == M_BRANCH);
    is_r = (op == M_OP);
    d.opcode = op;
    d.rd     = (is_s || is_b) ? 5'd0 : w[11:7];
    d.fun3   = w[14:12];
    d.rs1    = (is_u || is_j) ? 5'd0 : w[19:15];
    d.rs2    = (is_r || is_s || is_b) ? w[24:20] : 5'd0;
    d.fun7   = (is_r || (op == M_OPIMM && (w[14:12] == 3'd1 || w[14:12] == 3'd5)))
               ? w[31:25] : 7'd0;
    simm = 0;
    if (is_i) simm = int'($signed(w[31:20]));
    if (is_s) simm = int'($signed({w[31:25], w[11:7]}));
    if (is_b) simm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    if (is_j) simm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    d.imm = is_u ? {w[31:12], 12'h000} : 32'(simm);
    d.opc = pc;
    return d;
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return op inside {M_LUI, M_AUIPC, M_JAL, M_JALR, M_BRANCH, M_LOAD, M_STORE, M_OPIMM, M_OP};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: op = M_LUI;
      1: op = M_AUIPC;
      2: op = M_JAL;
      3: op = M_JALR;
      4: op = M_BRANCH;
      5: op = M_LOAD;
      6: op = M_STORE;
      7: op = M_OPIMM;
      8: op = M_OP;
      default: return NOP_W;
    endcase
    return {r[31:7], op};
  endfunction

  // Busy driver: single writer of is_busy, applied just after the falling edge
  initial begin
    bus.is_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.is_busy = busy_rand ? ($urandom_range(0, 3) == 0) : busy_level;
    end
  end

  always @(posedge clk) busy_q <= bus.is_busy;

  // Monitor: any non-NOP presentation is an issued instruction
  always @(negedge clk) begin
    dec_t got;
    dec_t exp;
    got = {bus.opcode, bus.rd, bus.fun3, bus.rs1, bus.rs2, bus.fun7, bus.imm, bus.opc};
    if (rst_n && (bus.opcode != M_OPIMM ||
                  {bus.rd, bus.fun3, bus.rs1, bus.rs2, bus.fun7, bus.imm, bus.opc} != '0)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_issue: got %h expected none", got);
      end else begin
        exp = sb_q.pop_front();
        check("issue_fields", got, exp);
      end
      check("issue_not_busy", {95'd0, busy_q}, 96'd0);
    end
  end

  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.imem_req && cyc < 80);
    if (!bus.imem_req) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch_timeout: got no imem_req expected addr %h", model_pc);
    end else begin
      check("fetch_addr", {64'd0, bus.imem_addr}, {64'd0, model_pc});
      check("queue_drained", 96'(sb_q.size()), 96'd0);
      check("not_halted", {95'd0, bus.halted}, 96'd0);
    end
  endtask

  task automatic serve(input logic [31:0] word, input int busy_n, input bit early,
                       input logic [31:0] npc_val, input int delay);
    dec_t d;
    int   flow;
    int   k;
    bit   saw;
    if (early) begin
      bus.get_npc = 1'b1;
      bus.npc     = ~model_pc;
      @(negedge clk);
      bus.get_npc = 1'b0;
    end
    repeat (delay) @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    flow = -1;
    if (word == NOP_W) begin
      model_pc = model_pc + 32'd4;
    end else if (ref_legal(word)) begin
      d = ref_decode(word, model_pc);
      sb_q.push_back(d);
      if (word[6:0] == M_BRANCH || word[6:0] == M_JALR) flow = 2;
      else if (word[6:0] == M_JAL) model_pc = model_pc + d.imm;
      else model_pc = model_pc + 32'd4;
    end
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom();
    if (busy_n > 0) begin
      busy_level = 1'b1;
      repeat (busy_n) @(negedge clk);
      check("held_while_busy", 96'(sb_q.size()), 96'd1);
      busy_level = 1'b0;
      @(negedge clk);
      #1;
      check("issue_after_busy", 96'(sb_q.size()), 96'd0);
    end
    if (flow == 2) begin
      k = 0;
      while (sb_q.size() != 0 && k < 80) begin
        @(negedge clk);
        k++;
      end
      saw = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        saw |= bus.imem_req;
      end
      check("no_fetch_brwait", {95'd0, saw}, 96'd0);
      bus.get_npc = 1'b1;
      bus.npc     = npc_val;
      @(negedge clk);
      bus.get_npc = 1'b0;
      model_pc    = npc_val;
    end
  endtask

  task automatic do_instr(input logic [31:0] word, input int busy_n, input bit early,
                          input logic [31:0] npc_val, input int delay);
    int cyc;
    wait_req(cyc);
    serve(word, busy_n, early, npc_val, delay);
  endtask

  task automatic check_nop_outputs(input string name);
    check(name, {bus.opcode, bus.rd, bus.fun3, bus.rs1, bus.rs2, bus.fun7, bus.imm, bus.opc},
          {M_OPIMM, 89'd0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [31:0] r;
    bit          saw;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.get_npc    = 1'b0;
    bus.npc        = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_nop_outputs("reset_nop");
    check("reset_req", {95'd0, bus.imem_req}, 96'd0);
    check("reset_halted", {95'd0, bus.halted}, 96'd0);
    rst_n    = 1'b1;
    model_pc = RST_PC;
    wait_req(cyc);
    check("first_req_latency", 96'(cyc), 96'd1);

    // Directed sequence
    serve(32'h0050_0093, 3, 1'b0, 32'h0, 0);              // ADDI x1,x0,5, busy 3 cycles
    do_instr(32'h0100_00EF, 0, 1'b0, 32'h0, 0);           // JAL x1,+16 at 0x104
    do_instr(32'h0020_8463, 0, 1'b1, 32'h0000_0200, 1);   // BEQ at 0x114, early get_npc ignored
    do_instr(NOP_W, 0, 1'b0, 32'h0, 0);                   // silent NOP at 0x200
    do_instr(32'h0000_80E7, 0, 1'b0, 32'hFFFF_FFFC, 2);   // JALR -> wrap point
    do_instr(32'h0050_0093, 0, 1'b0, 32'h0, 0);           // at 0xFFFFFFFC, next 0

    // Randomized traffic
    busy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r = $urandom();
      r[1:0] = 2'b00;
      do_instr(rand_word(), 0, ($urandom_range(0, 3) == 0), r, $urandom_range(0, 2));
    end
    busy_rand = 1'b0;

    // Illegal opcode halts
    do_instr(32'hFFFF_FFFF, 0, 1'b0, 32'h0, 0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw |= bus.imem_req;
    end
    check("halt_no_fetch", {95'd0, saw}, 96'd0);
    check("halted_set", {95'd0, bus.halted}, 96'd1);
    check_nop_outputs("halt_nop");

    // Reset out of HALT, then async reset while in WAIT with a stale ack
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("halted_cleared", {95'd0, bus.halted}, 96'd0);
    #2 rst_n = 1'b1;
    model_pc = RST_PC;
    wait_req(cyc);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_clear", {95'd0, bus.imem_req}, 96'd0);
    check_nop_outputs("async_nop");
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("stale_ack_req", {95'd0, bus.imem_req}, 96'd1);
    check("stale_ack_addr", {64'd0, bus.imem_addr}, {64'd0, RST_PC});
    serve(32'h0020_8093, 0, 1'b0, 32'h0, 0);              // ADDI x1,x1,2
    wait_req(cyc);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
